muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer that owns the architectural HI/LO register pair for the 32-bit MIPS datapath. The ALU issues mult/multu/div/divu and mthi/mtlo here. The pipeline stalls on `busy`, and mfhi/mflo read `hi`/`lo` directly. One shift-add/restoring-subtract step executes per cycle, so the block adds no combinational array multiplier or divider to the ALU critical path.

---
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv_unit.sv | 96 +++++++++
 tb/tb_muldiv_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the ALU issue stage and muldiv_unit
interface muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: 33-cycle iterative mult/div sequencer owning HI/LO; MULDIV_SIGNED_EN enables signed mult/div
module muldiv_unit (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t r_state, w_next;
  logic [4:0]  r_cnt;
  logic [32:0] r_p_hi;
  logic [31:0] r_p_lo, r_m, r_a, r_hi, r_lo;
  logic        r_div, r_dz, r_neg_q, r_neg_r, r_done, r_div_zero;
  logic        w_accept, w_muldiv, w_signed, w_neg_a, w_neg_b;
  logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_fix_hi, w_fix_lo;
  logic [32:0] w_sum, w_rsh;
  logic [33:0] w_diff;
  logic [63:0] w_prod, w_prod_f;
  assign w_accept = r_state == IDLE && bus.start;
  assign w_muldiv = w_accept && !bus.op[2];
`ifdef MULDIV_SIGNED_EN
  assign w_signed = bus.op[0];
  assign w_prod_f = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -r_p_lo : r_p_lo;
  assign w_r      = r_neg_r ? -r_p_hi[31:0] : r_p_hi[31:0];
`else
  assign w_signed = 1'b0;
  assign w_prod_f = w_prod;
  assign w_q      = r_p_lo;
  assign w_r      = r_p_hi[31:0];
`endif
  assign w_neg_a  = w_signed & bus.a[31];
  assign w_neg_b  = w_signed & bus.b[31];
  assign w_abs_a  = w_neg_a ? -bus.a : bus.a;
  assign w_abs_b  = w_neg_b ? -bus.b : bus.b;
  // Multiply step adds into the high half; divide step shifts {R,Q} and trial-subtracts
  assign w_sum    = r_p_hi + (r_p_lo[0] ? {1'b0, r_m} : 33'd0);
  assign w_rsh    = {r_p_hi[31:0], r_p_lo[31]};
  assign w_diff   = {1'b0, w_rsh} - {2'b0, r_m};
  assign w_prod   = {r_p_hi[31:0], r_p_lo};
  // Divide by zero bypasses sign correction and reports the original dividend
  assign w_fix_hi = r_dz ? r_a : r_div ? w_r : w_prod_f[63:32];
  assign w_fix_lo = r_dz ? 32'hFFFF_FFFF : r_div ? w_q : w_prod_f[31:0];
  always_comb begin
    w_next = (r_state == IDLE) ? (w_muldiv ? RUN : IDLE) :
             (r_state == RUN)  ? ((r_cnt == 5'd31) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_m <= '0;
      r_a <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_div <= 1'b0;
      r_dz <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= r_state == FIX;
      r_div_zero <= r_state == FIX && r_dz;
      if (w_muldiv) begin
        r_cnt <= '0;
        r_div <= bus.op[1];
        r_dz <= bus.op[1] && bus.b == 32'd0;
        r_a <= bus.a;
        r_m <= w_abs_b;
        r_p_hi <= '0;
        r_p_lo <= w_abs_a;
        r_neg_q <= w_neg_a ^ w_neg_b;
        r_neg_r <= w_neg_a;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 5'd1;
        r_p_hi <= r_div ? (w_diff[33] ? w_rsh : w_diff[32:0]) : {1'b0, w_sum[32:1]};
        r_p_lo <= r_div ? {r_p_lo[30:0], ~w_diff[33]} : {w_sum[0], r_p_lo[31:1]};
      end else if (r_state == FIX) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
      if (w_accept && bus.op == 3'b100) r_hi <= bus.a;
      if (w_accept && bus.op == 3'b101) r_lo <= bus.a;
    end
  end
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random mult/div/mthi/mtlo traffic against an arithmetic reference model
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  always #5 clk = ~clk;
  muldiv_if bus();
  muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic dz);
    logic s;
    logic [63:0] p;
    s = 1'b0;
`ifdef MULDIV_SIGNED_EN
    s = op[0];
`endif
    dz = 1'b0;
    if (op[2:1] == 2'b00) begin
      p = {{32{s & a[31]}}, a} * {{32{s & b[31]}}, b};
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (op[2:1] == 2'b01) begin
      if (b == 0) begin
        m_hi = a;
        m_lo = 32'hFFFF_FFFF;
        dz = 1'b1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_hi = 32'd0;
        m_lo = 32'h8000_0000;
      end else if (s) begin
        m_lo = $signed(a) / $signed(b);
        m_hi = $signed(a) % $signed(b);
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end else if (op == 3'b100) m_hi = a;
    else if (op == 3'b101) m_lo = a;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [31:0] oh, ol;
    logic dz;
    int n, nb;
    oh = m_hi;
    ol = m_lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    model(op, a, b, dz);
    if (op[2]) begin
      check("mt_hi", bus.hi, m_hi);
      check("mt_lo", bus.lo, m_lo);
      check("mt_busy", bus.busy, 0);
      return;
    end
    n = 0;
    nb = 0;
    while (!bus.done && n < 40) begin
      nb += int'(bus.busy);
      if (n == 16) begin
        check("hold_hi", bus.hi, oh);
        check("hold_lo", bus.lo, ol);
      end
      if (inject && n == 5) begin bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'd0; end
      if (inject && n == 6) begin bus.op = 3'b001; bus.a = 32'd7; bus.b = 32'd9; end
      if (inject && n == 7) bus.start = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, 33);
    check("busy_cycles", nb, 33);
    check("res_hi", bus.hi, m_hi);
    check("res_lo", bus.lo, m_lo);
    check("div_zero", bus.div_zero, dz);
    @(posedge clk);
    #1;
    check("done_pulse", bus.done, 0);
    check("idle_after", bus.busy, 0);
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'b001, 32'hFFFF_FFFD, 32'd5, 0);
    do_op(3'b010, 32'd100, 32'd7, 0);
    do_op(3'b011, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'b010, 32'h1234_5678, 32'd0, 0);
    do_op(3'b100, 32'hA5A5_A5A5, 32'd0, 0);
    do_op(3'b101, 32'h5A5A_5A5A, 32'd0, 0);
    do_op(3'b001, 32'd1234, 32'd5678, 1);
    do_op(3'b100, 32'hA5A5_A5A5, 32'd0, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    do_op(3'b010, 32'd9, 32'd3, 0);
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(rop, ra, rb, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
